keypad_emulator: RTL and testbench

- Synthesizable responder for the 4x4 keypad matrix: the row-drive/column-sense end of the scanning interface.
- Accepts "press key K for N cycles" commands and drives the column lines as a physical keypad would, including deterministic contact bounce on press and release.
- Used in-fabric and in benches as the stimulus target for the keypad scanner, synchronizer and debounce path.
- Runs on the slow scan clock domain.

---
 rtl/keypad_emulator.sv | 147 ++++++++++++++
 tb/tb_keypad_emulator.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_emulator.sv
// Keypad matrix responder: accepts "press key K for N cycles" commands and
// drives active-low column sense lines from the scanner's active-low row
// drive, with deterministic LFSR-based contact bounce on press and release.
module keypad_emulator #(
  parameter int unsigned BOUNCE_CYCLES = 64,
  parameter int unsigned BOUNCE_STEP   = 4,
  parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  rows,
  output logic [3:0]  cols,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_key,
  input  logic [15:0] cmd_hold,
  output logic        pressed,
  output logic        busy,
  output logic        done
);

  localparam int unsigned WinW  = (BOUNCE_CYCLES > 1) ? $clog2(BOUNCE_CYCLES) : 1;
  localparam int unsigned StepW = (BOUNCE_STEP > 1) ? $clog2(BOUNCE_STEP) : 1;
  localparam logic [WinW-1:0]  WinLast  = WinW'(BOUNCE_CYCLES - 1);
  localparam logic [StepW-1:0] StepLast = StepW'(BOUNCE_STEP - 1);

  typedef enum logic [1:0] {
    StIdle,
    StPressBounce,
    StHold,
    StReleaseBounce
  } state_e;

  state_e           state;
  logic             contact;
  logic [7:0]       lfsr;
  logic [WinW-1:0]  win_cnt;
  logic [StepW-1:0] step_cnt;
  logic [15:0]      hold_cnt;
  logic [3:0]       key;
  logic             lfsr_fb;
  logic [7:0]       lfsr_nxt;

  // Fibonacci LFSR x^8+x^6+x^5+x^4+1, shifting left with feedback into bit 0.
  always_comb begin
    lfsr_fb  = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
    lfsr_nxt = {lfsr[6:0], lfsr_fb};
  end

  assign cmd_ready = (state == StIdle);
  assign busy      = ~cmd_ready;
  assign pressed   = contact;

  // Command sequencing, bounce window timing and contact generation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= StIdle;
      contact  <= 1'b0;
      lfsr     <= LFSR_SEED;
      win_cnt  <= '0;
      step_cnt <= '0;
      hold_cnt <= '0;
      key      <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        StIdle: begin
          contact <= 1'b0;
          if (cmd_valid) begin
            key      <= cmd_key;
            hold_cnt <= (cmd_hold == 16'd0) ? 16'd1 : cmd_hold;
            win_cnt  <= '0;
            step_cnt <= '0;
            if (BOUNCE_CYCLES == 0) begin
              state   <= StHold;
              contact <= 1'b1;
            end else begin
              // First bounce step lands on the window's entry cycle.
              state   <= StPressBounce;
              lfsr    <= lfsr_nxt;
              contact <= lfsr_fb;
            end
          end
        end
        StPressBounce, StReleaseBounce: begin
          if (win_cnt == WinLast) begin
            win_cnt  <= '0;
            step_cnt <= '0;
            if (state == StPressBounce) begin
              state   <= StHold;
              contact <= 1'b1;
            end else begin
              state   <= StIdle;
              contact <= 1'b0;
              done    <= 1'b1;
            end
          end else begin
            win_cnt <= win_cnt + 1'b1;
            if (step_cnt == StepLast) begin
              step_cnt <= '0;
              lfsr     <= lfsr_nxt;
              contact  <= lfsr_fb;
            end else begin
              step_cnt <= step_cnt + 1'b1;
            end
          end
        end
        StHold: begin
          if (hold_cnt == 16'd1) begin
            if (BOUNCE_CYCLES == 0) begin
              state   <= StIdle;
              contact <= 1'b0;
              done    <= 1'b1;
            end else begin
              state    <= StReleaseBounce;
              lfsr     <= lfsr_nxt;
              contact  <= lfsr_fb;
              win_cnt  <= '0;
              step_cnt <= '0;
            end
          end else begin
            hold_cnt <= hold_cnt - 16'd1;
          end
        end
        default: begin
          state   <= StIdle;
          contact <= 1'b0;
        end
      endcase
    end
  end

  // Column sense: the key column is pulled low when contact is closed and
  // its row is driven; any row pattern is honoured as a real switch would.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cols <= 4'b1111;
    end else begin
      cols <= 4'b1111;
      if (contact && !rows[key[3:2]]) begin
        cols[key[1:0]] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_emulator.sv
// Randomized self-checking bench for keypad_emulator. Three instances with
// different bounce settings share the stimulus; one is selected at a time.
module tb_keypad_emulator;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  rows;
  logic        cmd_valid;
  logic [3:0]  cmd_key;
  logic [15:0] cmd_hold;
  int          sel;

  logic [3:0] cols_v [3];
  logic       rdy_v  [3];
  logic       busy_v [3];
  logic       pr_v   [3];
  logic       done_v [3];
  logic       cv_v   [3];

  logic [3:0] cols;
  logic       cmd_ready, busy, pressed, done;

  int unsigned bc_tab   [3] = '{0, 64, 7};
  int unsigned step_tab [3] = '{4, 4, 3};
  logic [7:0]  seed_tab [3] = '{8'hA5, 8'hA5, 8'h3C};

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  logic       q [$];
  logic [7:0] m_lfsr;
  logic       m_busy, m_pressed, m_done;
  logic [3:0] m_cols, m_key;
  int         rot;
  int         pcount;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 3; i++) cv_v[i] = cmd_valid && (sel == i);
    cols      = cols_v[sel];
    cmd_ready = rdy_v[sel];
    busy      = busy_v[sel];
    pressed   = pr_v[sel];
    done      = done_v[sel];
  end

  keypad_emulator #(.BOUNCE_CYCLES(0), .BOUNCE_STEP(4), .LFSR_SEED(8'hA5)) u_nb (
    .clk(clk), .reset(reset), .rows(rows), .cols(cols_v[0]), .cmd_valid(cv_v[0]),
    .cmd_ready(rdy_v[0]), .cmd_key(cmd_key), .cmd_hold(cmd_hold), .pressed(pr_v[0]),
    .busy(busy_v[0]), .done(done_v[0])
  );

  keypad_emulator u_def (
    .clk(clk), .reset(reset), .rows(rows), .cols(cols_v[1]), .cmd_valid(cv_v[1]),
    .cmd_ready(rdy_v[1]), .cmd_key(cmd_key), .cmd_hold(cmd_hold), .pressed(pr_v[1]),
    .busy(busy_v[1]), .done(done_v[1])
  );

  keypad_emulator #(.BOUNCE_CYCLES(7), .BOUNCE_STEP(3), .LFSR_SEED(8'h3C)) u_odd (
    .clk(clk), .reset(reset), .rows(rows), .cols(cols_v[2]), .cmd_valid(cv_v[2]),
    .cmd_ready(rdy_v[2]), .cmd_key(cmd_key), .cmd_hold(cmd_hold), .pressed(pr_v[2]),
    .busy(busy_v[2]), .done(done_v[2])
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h sel=%0d t=%0t", tag, got, exp, sel, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_lfsr    = seed_tab[sel];
    m_busy    = 1'b0;
    m_pressed = 1'b0;
    m_done    = 1'b0;
    m_cols    = 4'b1111;
    m_key     = 4'h0;
  endtask

  // Advance the bounce LFSR once; the new bit 0 is the contact level.
  task automatic lfsr_adv();
    logic fb;
    fb     = ^(m_lfsr & 8'hB8);
    m_lfsr = {m_lfsr[6:0], fb};
  endtask

  // Expand a command into its full per-cycle contact sequence.
  task automatic build_cmd(input logic [15:0] hold);
    int unsigned bc, st, n;
    bc = bc_tab[sel];
    st = step_tab[sel];
    n  = (hold == 16'd0) ? 1 : int'(hold);
    for (int unsigned k = 0; k < bc; k++) begin
      if (k % st == 0) lfsr_adv();
      q.push_back(m_lfsr[0]);
    end
    for (int unsigned k = 0; k < n; k++) q.push_back(1'b1);
    for (int unsigned k = 0; k < bc; k++) begin
      if (k % st == 0) lfsr_adv();
      q.push_back(m_lfsr[0]);
    end
  endtask

  // One clock: update the model for this edge, then check outputs after it.
  task automatic tick();
    logic [3:0] nc;
    nc = 4'b1111;
    if (m_pressed && !rows[m_key[3:2]]) nc[m_key[1:0]] = 1'b0;
    m_cols = nc;
    m_done = 1'b0;
    if (m_busy) begin
      if (q.size() == 0) begin
        m_busy    = 1'b0;
        m_pressed = 1'b0;
        m_done    = 1'b1;
      end else begin
        m_pressed = q.pop_front();
      end
    end else if (cmd_valid) begin
      m_key = cmd_key;
      build_cmd(cmd_hold);
      m_busy    = 1'b1;
      m_pressed = q.pop_front();
    end
    @(posedge clk);
    #1;
    check_eq("cols", 32'(cols), 32'(m_cols));
    check_eq("pressed", 32'(pressed), 32'(m_pressed));
    check_eq("busy", 32'(busy), 32'(m_busy));
    check_eq("cmd_ready", 32'(cmd_ready), 32'(!m_busy));
    check_eq("done", 32'(done), 32'(m_done));
    if (pressed) pcount++;
  endtask

  function automatic logic [3:0] pick_rows(input int mode, input logic [3:0] fixed);
    int r;
    logic [3:0] v;
    v = fixed;
    if (mode == 0) begin
      r = $urandom_range(0, 5);
      if (r < 4) v = ~(4'b0001 << r);
      else if (r == 4) v = 4'b0000;
      else v = 4'($urandom);
    end else if (mode == 1) begin
      v = ~(4'b0001 << (rot % 4));
    end
    return v;
  endfunction

  task automatic do_reset();
    reset     = 1'b0;
    cmd_valid = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check_eq("rst_cols", 32'(cols), 32'hF);
    check_eq("rst_ready", 32'(cmd_ready), 32'h1);
    check_eq("rst_busy", 32'(busy), 32'h0);
    check_eq("rst_pressed", 32'(pressed), 32'h0);
    check_eq("rst_done", 32'(done), 32'h0);
    reset = 1'b1;
    tick();
  endtask

  // Issue one command and run it to completion, optionally with junk requests.
  task automatic run_cmd(input logic [3:0] key, input logic [15:0] hold, input int mode,
                         input logic [3:0] fixed, input bit junk);
    int guard;
    guard     = 0;
    pcount    = 0;
    cmd_key   = key;
    cmd_hold  = hold;
    cmd_valid = 1'b1;
    rows      = pick_rows(mode, fixed);
    tick();
    cmd_valid = 1'b0;
    while (m_busy) begin
      rot++;
      rows = pick_rows(mode, fixed);
      if (junk) begin
        cmd_valid = 1'($urandom_range(0, 1));
        cmd_key   = 4'($urandom);
        cmd_hold  = 16'($urandom_range(0, 50));
      end
      tick();
      guard++;
      if (guard > 5000) begin
        check_eq("cmd_timeout", 32'(guard), 32'd0);
        break;
      end
    end
    cmd_valid = 1'b0;
    repeat ($urandom_range(1, 3)) begin
      rows = pick_rows(0, 4'hF);
      tick();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    sel       = 0;
    reset     = 1'b0;
    rows      = 4'b1111;
    cmd_valid = 1'b0;
    cmd_key   = 4'h0;
    cmd_hold  = 16'd0;
    rot       = 0;
    pcount    = 0;
    model_reset();
    #12;

    // No-bounce instance: rotating rows, busy rejection, hold=0 boundary.
    do_reset();
    run_cmd(4'b0110, 16'd10, 1, 4'hF, 1'b0);
    check_eq("nb_hold10_len", 32'(pcount), 32'd10);
    run_cmd(4'b0000, 16'd20, 0, 4'hF, 1'b1);
    check_eq("nb_hold20_len", 32'(pcount), 32'd20);
    run_cmd(4'($urandom), 16'd0, 2, 4'b0000, 1'b0);
    check_eq("nb_hold0_len", 32'(pcount), 32'd1);
    for (int i = 0; i < 6; i++) run_cmd(4'($urandom), 16'($urandom_range(0, 12)), 0, 4'hF, 1'b1);

    // Default bounce instance.
    sel = 1;
    do_reset();
    run_cmd(4'($urandom), 16'($urandom_range(1, 30)), 2, 4'b0000, 1'b0);
    run_cmd(4'($urandom), 16'd15, 2, 4'b1111, 1'b1);
    run_cmd(4'($urandom), 16'd0, 0, 4'hF, 1'b0);
    for (int i = 0; i < 4; i++) run_cmd(4'($urandom), 16'($urandom_range(0, 25)), 0, 4'hF, 1'b1);

    // Asynchronous reset in the middle of HOLD.
    cmd_key   = 4'b1001;
    cmd_hold  = 16'd40;
    cmd_valid = 1'b1;
    rows      = 4'b1011;
    tick();
    cmd_valid = 1'b0;
    repeat (64 + 5) tick();
    check_eq("hold_cols", 32'(cols), 32'b1101);
    #3;
    reset = 1'b0;
    #1;
    check_eq("async_cols", 32'(cols), 32'hF);
    check_eq("async_pressed", 32'(pressed), 32'h0);
    check_eq("async_busy", 32'(busy), 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    check_eq("async_ready", 32'(cmd_ready), 32'h1);
    reset = 1'b1;
    tick();
    run_cmd(4'b1001, 16'd5, 2, 4'b0000, 1'b0);

    // Window length not a multiple of the step, different seed.
    sel = 2;
    do_reset();
    for (int i = 0; i < 8; i++) run_cmd(4'($urandom), 16'($urandom_range(0, 10)), 0, 4'hF, 1'b1);
    run_cmd(4'($urandom), 16'd0, 2, 4'b0000, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
